wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Parametrised Wishbone-classic slave holding DEPTH addressable registers, each DSIZE bits wide, with byte-lane write enables.
- Provides software-visible control/status storage for peripherals on the SoC bus.
- Every register is also exported in parallel to fabric logic.
- One-wait-state handshake (IDLE -> ACK -> IDLE); optional bus-error signalling for unmapped addresses.

Parameters:
- DSIZE, 8, register/data width in bits; must be a multiple of 8.
- DEPTH, 4, number of registers; 1 <= DEPTH <= 2**AW.
- AW, 2, address width (word addresses).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cyc  in  1  Wishbone cycle valid.
- i_stb  in  1  Wishbone strobe.
- i_we  in  1  1 = write, 0 = read.
- i_adr  in  AW  word address.
- i_sel  in  DSIZE/8  byte-lane select for writes.
- i_dat  in  DSIZE  write data.
- o_ack  out  1  transfer acknowledge, one-cycle pulse.
- o_err  out  1  error acknowledge; only driven non-zero with WB_REGFILE_ERR_EN.
- o_dat  out  DSIZE  read data, registered.
- o_regs  out  DEPTH*DSIZE  flat copy of all registers; reg k at bits [k*DSIZE +: DSIZE].

Behaviour:
- Reset: on i_rst_n low, immediately and asynchronously:
  - state = IDLE, o_ack = 0, o_err = 0, o_dat = 0.
  - All registers = 0, so o_regs = 0.
- FSM has two states, IDLE and ACK.
  - IDLE -> ACK when i_cyc & i_stb is sampled high; otherwise stay in IDLE.
  - ACK -> IDLE unconditionally.
- o_ack is registered and high exactly in the ACK-state cycle, unless the access is an error under ERR_EN, in which case o_err is high instead.
- Request timing: request sampled at edge T (state IDLE). State is ACK during cycle T+1. The response occupies cycle T+1.
- Write (in range): at edge T, byte lane b of reg[i_adr] is updated from i_dat[8b+7:8b] only where i_sel[b] = 1. Other lanes hold. o_dat holds its previous value.
- Read (in range): at edge T, o_dat <= reg[i_adr]; i_sel is ignored.
- Throughput: the strobe is never sampled in ACK. Maximum rate is one transfer per 2 cycles; a new request may be sampled at edge T+1+1 if the master holds stb high.
- Out-of-range address (i_adr >= DEPTH):
  - Writes are ignored.
  - Reads load o_dat = 0.
  - Handshake per the Optional Feature below.
- i_cyc or i_stb dropping during ACK: the ack/err pulse still completes; the transfer has already committed.
- Reset asserted during ACK: the pulse is cut immediately. A write captured at edge T stays committed only if reset was not asserted before edge T.
- o_regs updates on the same edge as the write commit.

Optional Feature:
- Macro WB_REGFILE_ERR_EN.
- Defined: an out-of-range access pulses o_err, not o_ack, for its ACK cycle. Ignored-write/zero-read behaviour is unchanged.
- Undefined: o_err is tied 0 and out-of-range accesses receive a normal o_ack.

Decomposition:
- Package wb_pkg: FSM state encoding (WB_IDLE = 1'b0, WB_ACK = 1'b1) and a byte-mask merge function (old, new, sel) -> merged word.
- One natural sub-module, wb_slave_fsm: the IDLE/ACK handshake, producing a one-cycle take strobe and o_ack/o_err. Reusable by other bus slaves.
- Register storage and mux stay in wb_regfile.

Test Plan:
- Reset: hold i_rst_n low mid-run with regs non-zero -> o_ack = 0, o_dat = 0, o_regs = 0 immediately, without waiting for a clock edge.
- Full write/read (DSIZE = 32, DEPTH = 4):
  - Write reg2 = 0xDEADBEEF with i_sel = 4'hF -> o_ack high exactly one cycle after the strobe.
  - Read reg2 -> o_dat = 0xDEADBEEF during the ack cycle.
  - o_regs[95:64] = 0xDEADBEEF.
- Byte lanes: with reg1 = 0x11223344, write 0xAABBCCDD with i_sel = 4'b0101 -> reg1 reads 0x11BB33DD.
- Back-to-back: hold stb high across 4 reads of reg0..reg3 -> acks at cycles 1, 3, 5, 7 with the correct data each.
- Out of range (DEPTH = 3, adr = 3):
  - Write 0x55 -> no register changes.
  - Read -> o_dat = 0.
  - Without ERR_EN: o_ack pulses. With ERR_EN: o_err pulses and o_ack stays 0.
- Abort: drop i_cyc/i_stb during the ACK cycle of a write -> the ack pulse completes, the write is committed, and the FSM returns to IDLE with no second ack.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: handshake state encoding and byte-lane merge helper.
package wb_pkg;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_e;

  localparam int unsigned WB_MAX_DSIZE = 256;
  localparam int unsigned WB_MAX_LANES = WB_MAX_DSIZE / 8;

  // Callers zero-extend their operands to the maximum width and truncate the result back.
  function automatic logic [WB_MAX_DSIZE-1:0] wb_byte_merge(
    input logic [WB_MAX_DSIZE-1:0] old_word,
    input logic [WB_MAX_DSIZE-1:0] new_word,
    input logic [WB_MAX_LANES-1:0] sel
  );
    logic [WB_MAX_DSIZE-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < WB_MAX_LANES; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_slave_fsm.sv
// Wishbone-classic IDLE/ACK handshake: one-cycle take strobe, registered ack or err pulse.
module wb_slave_fsm
  import wb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cyc,
  input  logic i_stb,
  input  logic i_err_req,
  output logic o_take,
  output logic o_ack,
  output logic o_err
);

  wb_state_e state, state_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= WB_IDLE;
      o_ack <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_nxt;
      o_ack <= o_take & ~i_err_req;
      o_err <= o_take & i_err_req;
    end
  end

  always_comb begin
    state_nxt = state;
    o_take    = 1'b0;
    case (state)
      WB_IDLE: begin
        if (i_cyc && i_stb) begin
          o_take    = 1'b1;
          state_nxt = WB_ACK;
        end
      end
      WB_ACK:  state_nxt = WB_IDLE;
      default: state_nxt = WB_IDLE;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Wishbone-classic register file with byte-lane writes and a parallel export of every register.
// Define WB_REGFILE_ERR_EN to answer out-of-range accesses with o_err instead of o_ack.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cyc,
  input  logic                   i_stb,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_adr,
  input  logic [DSIZE/8-1:0]     i_sel,
  input  logic [DSIZE-1:0]       i_dat,
  output logic                   o_ack,
  output logic                   o_err,
  output logic [DSIZE-1:0]       o_dat,
  output logic [DEPTH*DSIZE-1:0] o_regs
);

  logic [DSIZE-1:0] regs [DEPTH];
  logic [DSIZE-1:0] rd_word;
  logic             oor;
  logic             err_req;
  logic             take;

  always_comb oor = (32'(i_adr) >= DEPTH);

`ifdef WB_REGFILE_ERR_EN
  always_comb err_req = oor;
`else
  always_comb err_req = 1'b0;
`endif

  wb_slave_fsm u_fsm (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_cyc     (i_cyc),
    .i_stb     (i_stb),
    .i_err_req (err_req),
    .o_take    (take),
    .o_ack     (o_ack),
    .o_err     (o_err)
  );

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (i_adr == AW'(k)) rd_word = regs[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) regs[k] <= '0;
      o_dat <= '0;
    end else if (take) begin
      if (i_we) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!oor && i_adr == AW'(k)) begin
            regs[k] <= DSIZE'(wb_byte_merge(WB_MAX_DSIZE'(regs[k]),
                                            WB_MAX_DSIZE'(i_dat),
                                            WB_MAX_LANES'(i_sel)));
          end
        end
      end else begin
        o_dat <= oor ? '0 : rd_word;
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int unsigned k = 0; k < DEPTH; k++) o_regs[k*DSIZE +: DSIZE] = regs[k];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand sequences and randomized model checks.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc0, cyc3, stb, we;
  logic [1:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic        ack0, err0, ack3, err3;
  logic [31:0] dat0, dat3;
  logic [127:0] regs0;
  logic [95:0]  regs3;

  wb_regfile #(.DSIZE(32), .DEPTH(4), .AW(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc0), .i_stb(stb), .i_we(we),
    .i_adr(adr), .i_sel(sel), .i_dat(dat),
    .o_ack(ack0), .o_err(err0), .o_dat(dat0), .o_regs(regs0)
  );

  wb_regfile #(.DSIZE(32), .DEPTH(3), .AW(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc3), .i_stb(stb), .i_we(we),
    .i_adr(adr), .i_sel(sel), .i_dat(dat),
    .o_ack(ack3), .o_err(err3), .o_dat(dat3), .o_regs(regs3)
  );

`ifdef WB_REGFILE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] m0 [4];
  logic [31:0] m3 [3];
  logic [31:0] last0, last3;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] flat0();
    return {m0[3], m0[2], m0[1], m0[0]};
  endfunction

  function automatic logic [127:0] flat3();
    return {32'h0, m3[2], m3[1], m3[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m0[i] = '0;
    for (int i = 0; i < 3; i++) m3[i] = '0;
    last0 = '0;
    last3 = '0;
  endtask

  // Reference behaviour: byte-masked write, zero read outside the mapped range.
  task automatic model_apply(input bit which3, input logic w, input logic [1:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] exp_dat, output logic exp_ack,
                             output logic exp_err);
    int depth;
    bit in_range;
    logic [31:0] mask, old;
    depth    = which3 ? 3 : 4;
    in_range = (int'(a) < depth);
    mask = '0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    if (w) begin
      if (in_range) begin
        old = which3 ? m3[a] : m0[a];
        if (which3) m3[a] = (old & ~mask) | (d & mask);
        else        m0[a] = (old & ~mask) | (d & mask);
      end
    end else begin
      if (which3) last3 = in_range ? m3[a] : 32'h0;
      else        last0 = in_range ? m0[a] : 32'h0;
    end
    exp_dat = which3 ? last3 : last0;
    exp_err = !in_range && ERR_EN;
    exp_ack = !exp_err;
  endtask

  // Single transfer: strobe sampled at one edge, dropped right after it (abort during ACK).
  task automatic xfer(input bit which3, input logic w, input logic [1:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic r_ack, output logic r_err, output logic [31:0] r_dat,
                      output logic r_after);
    @(negedge clk);
    if (which3) cyc3 = 1'b1; else cyc0 = 1'b1;
    stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(posedge clk); #1;
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0;
    r_ack = which3 ? ack3 : ack0;
    r_err = which3 ? err3 : err0;
    r_dat = which3 ? dat3 : dat0;
    @(posedge clk); #1;
    r_after = which3 ? (ack3 | err3) : (ack0 | err0);
  endtask

  task automatic run_op(input string tag, input bit which3, input logic w, input logic [1:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    logic [31:0] e_dat, g_dat;
    logic e_ack, e_err, g_ack, g_err, g_after;
    model_apply(which3, w, a, s, d, e_dat, e_ack, e_err);
    xfer(which3, w, a, s, d, g_ack, g_err, g_dat, g_after);
    check({tag, ".ack"}, 128'(g_ack), 128'(e_ack));
    check({tag, ".err"}, 128'(g_err), 128'(e_err));
    check({tag, ".dat"}, 128'(g_dat), 128'(e_dat));
    check({tag, ".no_second"}, 128'(g_after), 128'(0));
    check({tag, ".regs"}, which3 ? 128'(regs3) : regs0, which3 ? flat3() : flat0());
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    logic        exp_ack;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [31:0] e_dat, g_dat;
    logic e_ack, e_err, g_ack, g_err, g_after;

    cyc0 = 0; cyc3 = 0; stb = 0; we = 0; adr = 0; sel = 0; dat = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset.ack", 128'(ack0), 128'(0));
    check("reset.err", 128'(err0), 128'(0));
    check("reset.dat", 128'(dat0), 128'(0));
    check("reset.regs", regs0, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vt[0] = '{1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b1};
    vt[1] = '{1'b0, 2'd2, 4'h0, 32'h00000000, 32'hDEADBEEF, 1'b1};
    vt[2] = '{1'b1, 2'd1, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b1};
    vt[3] = '{1'b1, 2'd1, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF, 1'b1};
    vt[4] = '{1'b0, 2'd1, 4'h3, 32'hFFFFFFFF, 32'h11BB33DD, 1'b1};
    vt[5] = '{1'b1, 2'd0, 4'h8, 32'h12345678, 32'h11BB33DD, 1'b1};
    vt[6] = '{1'b0, 2'd0, 4'hF, 32'h00000000, 32'h12000000, 1'b1};
    vt[7] = '{1'b0, 2'd3, 4'hF, 32'h00000000, 32'h00000000, 1'b1};
    for (int i = 0; i < 8; i++) begin
      model_apply(1'b0, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, e_dat, e_ack, e_err);
      xfer(1'b0, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, g_ack, g_err, g_dat, g_after);
      check($sformatf("vec%0d.ack", i), 128'(g_ack), 128'(vt[i].exp_ack));
      check($sformatf("vec%0d.dat", i), 128'(g_dat), 128'(vt[i].exp_dat));
      check($sformatf("vec%0d.no_second", i), 128'(g_after), 128'(0));
    end
    check("regs0.reg2", 128'(regs0[95:64]), 128'(32'hDEADBEEF));

    // Back-to-back reads with stb held: acks after edges 0, 2, 4, 6.
    @(negedge clk);
    cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0; sel = 4'h0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("b2b.ack%0d", c), 128'(ack0), 128'((c % 2) == 0));
      if ((c % 2) == 0) begin
        check($sformatf("b2b.dat%0d", c), 128'(dat0), 128'(m0[c / 2]));
        if (c == 6) begin
          cyc0 = 1'b0; stb = 1'b0;
        end else begin
          adr = 2'(c / 2 + 1);
        end
      end
    end
    last0 = m0[3];

    // Out-of-range on the DEPTH=3 instance.
    run_op("oor.prep_w", 1'b1, 1'b1, 2'd2, 4'hF, 32'h00000077);
    run_op("oor.prep_r", 1'b1, 1'b0, 2'd2, 4'hF, 32'h0);
    run_op("oor.write", 1'b1, 1'b1, 2'd3, 4'hF, 32'h00000055);
    run_op("oor.read", 1'b1, 1'b0, 2'd3, 4'hF, 32'h0);

    // Reset asserted during the ACK cycle of a read: pulse and state cleared without a clock edge.
    @(negedge clk);
    cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
    @(posedge clk); #1;
    cyc0 = 1'b0; stb = 1'b0;
    check("rst_mid.pre_ack", 128'(ack0), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.ack", 128'(ack0), 128'(0));
    check("rst_mid.dat", 128'(dat0), 128'(0));
    check("rst_mid.regs", regs0, 128'(0));
    check("rst_mid.regs3", 128'(regs3), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) begin
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 4'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
